lcd_exe_arbiter: RTL and testbench
==================================

# lcd_exe_arbiter

Shares the single LCD executor (4-bit op, 8-bit data, ready-based handshake) between up to NREQ independent requesters: score command sequencer, banner/message writer, init sequencer. Grants one transfer at a time in round-robin order, supports locked multi-transfer bursts (cursor-set then characters), and recovers from an executor that never accepts a command. Sits between the command-level blocks and the executor inside the LCD controller.

## Interface
- NREQ, 3, number of requesters (2..8)
- ACK_TIMEOUT, 255, max cycles from exe_start to exe_rdy falling before abort
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-low
- req_valid  in  NREQ  request pending, one bit per requester
- req_lock  in  NREQ  keep ownership after this transfer completes
- req_op  in  4*NREQ  executor op, requester i at bits [4i+3:4i]
- req_data  in  8*NREQ  executor data, requester i at bits [8i+7:8i]
- req_ack  out  NREQ  one-cycle pulse: requester's transfer finished
- exe_op  out  4  op to executor, registered at grant
- exe_data  out  8  data to executor, registered at grant
- exe_start  out  1  one-cycle start strobe to executor
- exe_rdy  in  1  executor idle/ready (high = idle)
- busy  out  1  high whenever state != IDLE
- owner  out  3  index of current/last granted requester
- locked  out  1  ownership held by owner
- err_timeout  out  1  one-cycle pulse on accept timeout

## Operation
- States: IDLE, ISSUE, WAIT_ACK, WAIT_DONE, ACK.
- IDLE: grant only if exe_rdy=1 and a candidate exists. Unlocked: candidate = first valid requester searching from ptr upward, wrapping at NREQ. Locked: only owner is a candidate; if req_valid[owner]=0 and req_lock[owner]=0, clear locked this cycle, no grant (normal arbitration next cycle). Grant: latch exe_op/exe_data from winner, owner<=winner, -> ISSUE.
- ISSUE: exe_start=1 for exactly one cycle, timeout counter cleared, -> WAIT_ACK.
- WAIT_ACK: exe_rdy=0 -> WAIT_DONE. Counter reaches ACK_TIMEOUT -> err_timeout pulse, no req_ack, locked<=0, ptr<=owner+1 (wrap), -> IDLE.
- WAIT_DONE: exe_rdy=1 -> ACK. No timeout here.
- ACK: req_ack[owner]=1 for one cycle; locked<=req_lock[owner]; ptr<=locked ? owner : owner+1 (wrap); -> IDLE.
- Requester rule: hold valid/op/data/lock stable until ack; op/data are sampled only at grant. Registered requesters see ack at the edge ending ACK, so IDLE sees updated valid.
- Requesters with index >= NREQ do not exist; owner width fixed 3 bits.
- exe_op/exe_data hold their value between transfers.

## Timing
- Reset (rst=0 at clk edge): state IDLE, ptr 0, owner 0, locked 0, exe_op 0, exe_data 0, exe_start 0, req_ack 0, busy 0, err_timeout 0. Reset mid-transfer abandons it without ack; executor reset is separate.
- Grant at cycle N (IDLE) -> exe_start high in N+1 -> earliest req_ack at N+4 (exe_rdy falls in N+2, rises in N+3).
- Back-to-back: after ACK, next grant earliest in the following IDLE cycle; minimum 5 cycles per transfer.
- exe_rdy=0 in IDLE: hold in IDLE, no grant, no timeout counting.
- Simultaneous requests: resolved purely by ptr; every valid requester is served within NREQ transfers when no lock is held.
- Lock held while owner drops valid but keeps lock: arbiter waits indefinitely (intended; burst owner guarantees progress).
- All outputs registered.

## Structure
- Shared package lcd_pkg: executor op codes (CLEAR, SET_CURSOR, WRITE_CHAR, NOP=15), LCD_OP_W=4, LCD_DATA_W=8, arbiter state enum.
- Sub-module rr_pick: combinational round-robin picker (valid vector, ptr -> found, index); one instance.
- Timeout counter width $clog2(ACK_TIMEOUT+1).

## Test plan
- Single request: req_valid=001, op=2, data=0x35, executor model 1-cycle accept/3-cycle busy -> exe_start one cycle with exe_op=2/exe_data=0x35, req_ack=001 pulse, busy low afterwards.
- Contention: req_valid=111 held, each drops on its ack -> grants order 0,1,2; then re-raise 111 with ptr=0 -> 0,1,2 again; no requester served twice before all served.
- Lock burst: req0 lock=1 for 3 transfers (SET_CURSOR 0x40, WRITE 0x31, WRITE 0x32), req1 valid throughout -> all three req0 transfers before req1's first ack.
- Timeout: executor holds exe_rdy=1 after exe_start, ACK_TIMEOUT=8 -> err_timeout pulse 8 cycles after exe_start, no req_ack, next grant goes to next requester.
- Executor not ready: exe_rdy=0 for 20 cycles with req_valid=010 -> no exe_start until exe_rdy=1, then grant within 1 cycle.
- Reset mid-op: rst=0 during WAIT_DONE -> next cycle all outputs at reset values, no req_ack; request reissued after reset completes normally.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared LCD controller definitions: executor op codes, bus widths and
// the executor arbiter state encoding.
package lcd_pkg;

  localparam int unsigned LCD_OP_W   = 4;
  localparam int unsigned LCD_DATA_W = 8;

  typedef enum logic [LCD_OP_W-1:0] {
    OP_CLEAR      = 4'd0,
    OP_SET_CURSOR = 4'd1,
    OP_WRITE_CHAR = 4'd2,
    OP_NOP        = 4'd15
  } lcd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_ACK,
    ST_WAIT_DONE,
    ST_ACK
  } arb_state_e;

  // Next requester index, wrapping at n.
  function automatic logic [2:0] wrap_inc(input logic [2:0] idx, input int unsigned n);
    int unsigned nxt;
    nxt = 32'(idx) + 1;
    return (nxt >= n) ? 3'd0 : 3'(nxt);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of valid_i searching
// upward from ptr_i and wrapping at NREQ.
module rr_pick
  import lcd_pkg::*;
#(
  parameter int unsigned NREQ = 3
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic [2:0]      ptr_i,
  output logic            found_o,
  output logic [2:0]      idx_o
);

  always_comb begin
    int unsigned j;
    logic        hit;
    found_o = 1'b0;
    idx_o   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      j = 32'(ptr_i) + k;
      if (j >= NREQ) j = j - NREQ;
      hit = 1'b0;
      for (int unsigned m = 0; m < NREQ; m++) begin
        if (m == j) hit = valid_i[m];
      end
      if (!found_o && hit) begin
        found_o = 1'b1;
        idx_o   = 3'(j);
      end
    end
  end

endmodule

// File: rtl/lcd_exe_arbiter.sv
// Round-robin arbiter sharing the single LCD executor between NREQ
// requesters, with locked bursts and an executor accept timeout.
module lcd_exe_arbiter
  import lcd_pkg::*;
#(
  parameter int unsigned NREQ        = 3,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ-1:0]            req_lock,
  input  logic [LCD_OP_W*NREQ-1:0]   req_op,
  input  logic [LCD_DATA_W*NREQ-1:0] req_data,
  output logic [NREQ-1:0]            req_ack,
  output logic [LCD_OP_W-1:0]        exe_op,
  output logic [LCD_DATA_W-1:0]      exe_data,
  output logic                       exe_start,
  input  logic                       exe_rdy,
  output logic                       busy,
  output logic [2:0]                 owner,
  output logic                       locked,
  output logic                       err_timeout
);

  localparam int unsigned CW = $clog2(ACK_TIMEOUT + 1);

  arb_state_e             state_q, state_d;
  logic [2:0]             ptr_q, ptr_d;
  logic [2:0]             owner_q, owner_d;
  logic                   locked_q, locked_d;
  logic [LCD_OP_W-1:0]    exe_op_q, exe_op_d;
  logic [LCD_DATA_W-1:0]  exe_data_q, exe_data_d;
  logic                   exe_start_q, exe_start_d;
  logic [NREQ-1:0]        req_ack_q, req_ack_d;
  logic                   err_q, err_d;
  logic                   busy_q;
  logic [CW-1:0]          cnt_q, cnt_d;

  logic                   pick_found;
  logic [2:0]             pick_idx;
  logic [2:0]             gnt_idx;
  logic                   own_valid, own_lock;
  logic [LCD_OP_W-1:0]    gnt_op;
  logic [LCD_DATA_W-1:0]  gnt_data;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .valid_i (req_valid),
    .ptr_i   (ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  assign gnt_idx = locked_q ? owner_q : pick_idx;

  always_comb begin
    own_valid = 1'b0;
    own_lock  = 1'b0;
    gnt_op    = '0;
    gnt_data  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (owner_q == 3'(k)) begin
        own_valid = req_valid[k];
        own_lock  = req_lock[k];
      end
      if (gnt_idx == 3'(k)) begin
        gnt_op   = req_op[k*LCD_OP_W +: LCD_OP_W];
        gnt_data = req_data[k*LCD_DATA_W +: LCD_DATA_W];
      end
    end
  end

  // Pulse outputs are computed for the state being entered so that they
  // are registered yet coincide with that state.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    locked_d    = locked_q;
    exe_op_d    = exe_op_q;
    exe_data_d  = exe_data_q;
    cnt_d       = cnt_q;
    exe_start_d = 1'b0;
    req_ack_d   = '0;
    err_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (locked_q && !own_valid && !own_lock) begin
          locked_d = 1'b0;
        end else if (exe_rdy && (locked_q ? own_valid : pick_found)) begin
          exe_op_d    = gnt_op;
          exe_data_d  = gnt_data;
          owner_d     = gnt_idx;
          exe_start_d = 1'b1;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = CW'(1);
        state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (!exe_rdy) begin
          state_d = ST_WAIT_DONE;
        end else if (cnt_q >= CW'(ACK_TIMEOUT - 1)) begin
          err_d    = 1'b1;
          locked_d = 1'b0;
          ptr_d    = wrap_inc(owner_q, NREQ);
          state_d  = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (exe_rdy) begin
          for (int unsigned k = 0; k < NREQ; k++) begin
            req_ack_d[k] = (owner_q == 3'(k));
          end
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        locked_d = own_lock;
        ptr_d    = own_lock ? owner_q : wrap_inc(owner_q, NREQ);
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      locked_q    <= 1'b0;
      exe_op_q    <= '0;
      exe_data_q  <= '0;
      exe_start_q <= 1'b0;
      req_ack_q   <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      locked_q    <= locked_d;
      exe_op_q    <= exe_op_d;
      exe_data_q  <= exe_data_d;
      exe_start_q <= exe_start_d;
      req_ack_q   <= req_ack_d;
      err_q       <= err_d;
      busy_q      <= (state_d != ST_IDLE);
      cnt_q       <= cnt_d;
    end
  end

  assign req_ack     = req_ack_q;
  assign exe_op      = exe_op_q;
  assign exe_data    = exe_data_q;
  assign exe_start   = exe_start_q;
  assign busy        = busy_q;
  assign owner       = owner_q;
  assign locked      = locked_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_lcd_exe_arbiter.sv
// Directed bench for lcd_exe_arbiter with a behavioural executor model.
module tb_lcd_exe_arbiter;
  import lcd_pkg::*;

  localparam int unsigned NREQ = 3;
  localparam int unsigned TMO  = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_lock = '0;
  logic [4*NREQ-1:0] req_op = '0;
  logic [8*NREQ-1:0] req_data = '0;
  logic [NREQ-1:0]   req_ack;
  logic [3:0]        exe_op;
  logic [7:0]        exe_data;
  logic              exe_start;
  logic              exe_rdy = 1'b1;
  logic              busy;
  logic [2:0]        owner;
  logic              locked;
  logic              err_timeout;

  lcd_exe_arbiter #(.NREQ(NREQ), .ACK_TIMEOUT(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_lock    (req_lock),
    .req_op      (req_op),
    .req_data    (req_data),
    .req_ack     (req_ack),
    .exe_op      (exe_op),
    .exe_data    (exe_data),
    .exe_start   (exe_start),
    .exe_rdy     (exe_rdy),
    .busy        (busy),
    .owner       (owner),
    .locked      (locked),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  // Executor: drops ready the cycle after start, for busy_len cycles.
  logic exe_stuck = 1'b0;
  logic exe_force_low = 1'b0;
  int   busy_len = 1;
  int   busy_left = 0;
  always @(posedge clk) begin
    if (!rst) begin
      exe_rdy   <= 1'b1;
      busy_left <= 0;
    end else if (exe_force_low) begin
      exe_rdy <= 1'b0;
    end else if (exe_start && !exe_stuck) begin
      exe_rdy   <= 1'b0;
      busy_left <= busy_len;
    end else if (busy_left > 1) begin
      busy_left <= busy_left - 1;
    end else begin
      busy_left <= 0;
      exe_rdy   <= 1'b1;
    end
  end

  typedef struct {
    logic [2:0] own;
    logic [7:0] dat;
  } gnt_t;

  typedef struct {
    int         idx;
    logic [3:0] op;
    logic [7:0] data;
    int         blen;
    int         exp_delay;
  } vec_t;

  gnt_t            gq[$];
  logic [NREQ-1:0] aq[$];
  logic            auto_drop = 1'b1;
  int              errors = 0;
  int              checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (exe_start) gq.push_back('{own: owner, dat: exe_data});
    if (req_ack != '0) begin
      aq.push_back(req_ack);
      if (auto_drop) req_valid = req_valid & ~req_ack;
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic l,
                         input logic [3:0] op, input logic [7:0] d);
    req_valid[i]     = v;
    req_lock[i]      = l;
    req_op[4*i +: 4] = op;
    req_data[8*i +: 8] = d;
  endtask

  task automatic wait_start(input int lim, output int n);
    n = 0;
    do begin tick(); n++; end while (!exe_start && n < lim);
    chk("start_seen", 32'(exe_start), 32'd1);
  endtask

  task automatic wait_ack(input int lim, output int n);
    n = 0;
    do begin tick(); n++; end while (req_ack == '0 && n < lim);
    chk("ack_seen", 32'(req_ack != '0), 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_owner"}, 32'(owner), 32'd0);
    chk({tag, "_locked"}, 32'(locked), 32'd0);
    chk({tag, "_exe_op"}, 32'(exe_op), 32'd0);
    chk({tag, "_exe_data"}, 32'(exe_data), 32'd0);
    chk({tag, "_exe_start"}, 32'(exe_start), 32'd0);
    chk({tag, "_req_ack"}, 32'(req_ack), 32'd0);
    chk({tag, "_err"}, 32'(err_timeout), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[4];
    int   n;
    int   starts;

    vecs[0] = '{idx: 0, op: OP_WRITE_CHAR, data: 8'h35, blen: 3, exp_delay: 5};
    vecs[1] = '{idx: 2, op: OP_SET_CURSOR, data: 8'h40, blen: 1, exp_delay: 3};
    vecs[2] = '{idx: 1, op: OP_CLEAR,      data: 8'h00, blen: 2, exp_delay: 4};
    vecs[3] = '{idx: 2, op: OP_NOP,        data: 8'hFF, blen: 1, exp_delay: 3};

    // Reset state
    repeat (3) tick();
    chk_reset_vals("rst");
    rst = 1'b1;
    tick();

    // Single-requester transfers from the table
    for (int v = 0; v < 4; v++) begin
      busy_len = vecs[v].blen;
      set_req(vecs[v].idx, 1'b1, 1'b0, vecs[v].op, vecs[v].data);
      wait_start(10, n);
      chk("vec_start_lat", 32'(n), 32'd1);
      chk("vec_exe_op", 32'(exe_op), 32'(vecs[v].op));
      chk("vec_exe_data", 32'(exe_data), 32'(vecs[v].data));
      chk("vec_owner", 32'(owner), 32'(vecs[v].idx));
      wait_ack(30, n);
      chk("vec_ack_delay", 32'(n), 32'(vecs[v].exp_delay));
      chk("vec_ack_val", 32'(req_ack), 32'd1 << vecs[v].idx);
      tick();
      chk("vec_ack_clear", 32'(req_ack), 32'd0);
      chk("vec_busy_low", 32'(busy), 32'd0);
      chk("vec_op_hold", 32'(exe_op), 32'(vecs[v].op));
    end

    // Contention: two rounds of all three requesters
    busy_len = 1;
    for (int r = 0; r < 2; r++) begin
      gq.delete();
      for (int k = 0; k < 3; k++) set_req(k, 1'b1, 1'b0, OP_WRITE_CHAR, 8'(8'hA0 + 16*r + k));
      n = 0;
      while (req_valid != '0 && n < 60) begin tick(); n++; end
      chk("cont_done", 32'(req_valid), 32'd0);
      chk("cont_count", 32'(gq.size()), 32'd3);
      for (int k = 0; k < 3 && k < gq.size(); k++) begin
        chk("cont_order", 32'(gq[k].own), 32'(k));
        chk("cont_data", 32'(gq[k].dat), 32'(8'hA0 + 16*r + k));
      end
      tick();
    end

    // Locked burst from requester 0 while requester 1 waits
    gq.delete();
    aq.delete();
    auto_drop = 1'b0;
    set_req(0, 1'b1, 1'b1, OP_SET_CURSOR, 8'h40);
    set_req(1, 1'b1, 1'b0, OP_WRITE_CHAR, 8'h41);
    wait_ack(30, n);
    @(posedge clk); #1;
    set_req(0, 1'b1, 1'b1, OP_WRITE_CHAR, 8'h31);
    tick();
    chk("burst_locked", 32'(locked), 32'd1);
    wait_ack(30, n);
    @(posedge clk); #1;
    set_req(0, 1'b1, 1'b0, OP_WRITE_CHAR, 8'h32);
    wait_ack(30, n);
    @(posedge clk); #1;
    set_req(0, 1'b0, 1'b0, OP_NOP, 8'h00);
    wait_ack(30, n);
    @(posedge clk); #1;
    set_req(1, 1'b0, 1'b0, OP_NOP, 8'h00);
    tick();
    chk("burst_acks", 32'(aq.size()), 32'd4);
    chk("burst_grants", 32'(gq.size()), 32'd4);
    if (aq.size() == 4 && gq.size() == 4) begin
      chk("burst_ack0", 32'(aq[0]), 32'd1);
      chk("burst_ack1", 32'(aq[1]), 32'd1);
      chk("burst_ack2", 32'(aq[2]), 32'd1);
      chk("burst_ack3", 32'(aq[3]), 32'd2);
      chk("burst_d0", 32'(gq[0].dat), 32'h40);
      chk("burst_d1", 32'(gq[1].dat), 32'h31);
      chk("burst_d2", 32'(gq[2].dat), 32'h32);
      chk("burst_d3", 32'(gq[3].dat), 32'h41);
      chk("burst_own3", 32'(gq[3].own), 32'd1);
    end
    chk("burst_unlocked", 32'(locked), 32'd0);
    auto_drop = 1'b1;

    // Accept timeout: ptr sits at 2 so requester 0 wins first
    gq.delete();
    aq.delete();
    exe_stuck = 1'b1;
    set_req(0, 1'b1, 1'b0, OP_CLEAR, 8'h00);
    set_req(1, 1'b1, 1'b0, OP_WRITE_CHAR, 8'h55);
    wait_start(10, n);
    chk("tmo_owner", 32'(owner), 32'd0);
    n = 0;
    do begin tick(); n++; end while (!err_timeout && n < 20);
    chk("tmo_delay", 32'(n), 32'(TMO));
    chk("tmo_busy", 32'(busy), 32'd0);
    chk("tmo_no_ack", 32'(aq.size()), 32'd0);
    exe_stuck = 1'b0;
    tick();
    chk("tmo_pulse_end", 32'(err_timeout), 32'd0);
    n = 0;
    while (req_valid != '0 && n < 60) begin tick(); n++; end
    chk("tmo_grants", 32'(gq.size()), 32'd3);
    if (gq.size() == 3) begin
      chk("tmo_next_owner", 32'(gq[1].own), 32'd1);
      chk("tmo_retry_owner", 32'(gq[2].own), 32'd0);
    end
    tick();

    // Executor not ready holds the arbiter in idle
    exe_force_low = 1'b1;
    tick();
    set_req(1, 1'b1, 1'b0, OP_WRITE_CHAR, 8'h77);
    starts = 0;
    repeat (20) begin tick(); if (exe_start) starts++; end
    chk("nrdy_no_start", 32'(starts), 32'd0);
    chk("nrdy_busy", 32'(busy), 32'd0);
    exe_force_low = 1'b0;
    n = 0;
    do begin tick(); n++; end while (!exe_rdy && n < 5);
    chk("nrdy_rdy_back", 32'(exe_rdy), 32'd1);
    tick();
    chk("nrdy_start", 32'(exe_start), 32'd1);
    chk("nrdy_owner", 32'(owner), 32'd1);
    chk("nrdy_data", 32'(exe_data), 32'h77);
    wait_ack(30, n);
    tick();

    // Reset during WAIT_DONE, then the request completes afterwards
    busy_len = 3;
    set_req(2, 1'b1, 1'b0, OP_WRITE_CHAR, 8'h5A);
    wait_start(10, n);
    tick();
    tick();
    chk("mid_busy", 32'(busy), 32'd1);
    aq.delete();
    rst = 1'b0;
    tick();
    chk_reset_vals("mid");
    rst = 1'b1;
    wait_start(10, n);
    chk("mid_restart_lat", 32'(n), 32'd1);
    chk("mid_owner", 32'(owner), 32'd2);
    chk("mid_data", 32'(exe_data), 32'h5A);
    chk("mid_no_ack", 32'(aq.size()), 32'd0);
    wait_ack(30, n);
    chk("mid_ack_delay", 32'(n), 32'd5);
    chk("mid_ack_val", 32'(req_ack), 32'd4);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
